// File: rtl/inv_mix_columns.sv
// AES InvMixColumns, COLS_PER_CYCLE columns per clock; result 4/COLS_PER_CYCLE cycles after acceptance.
// Busy while transforming and holding a result: in_ready low until state_out is taken by out_ready.
module inv_mix_columns #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_out
);

   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_cfg_err
      $error("inv_mix_columns: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t         state_q, state_d;
   logic [127:0]   work;
   logic [127:0]   work_nxt;
   logic [1:0]     idx;
   logic [1:0]     col;
   logic           last;
   int             base;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul9(input logic [7:0] b);
      return xt(xt(xt(b))) ^ b;
   endfunction

   function automatic logic [7:0] mulb(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(b) ^ b;
   endfunction

   function automatic logic [7:0] muld(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
   endfunction

   function automatic logic [7:0] mule(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
   endfunction

   function automatic logic [31:0] inv_col(input logic [31:0] c);
      logic [7:0] b0, b1, b2, b3;
      {b0, b1, b2, b3} = c;
      return {mule(b0) ^ mulb(b1) ^ muld(b2) ^ mul9(b3),
              mul9(b0) ^ mule(b1) ^ mulb(b2) ^ muld(b3),
              muld(b0) ^ mul9(b1) ^ mule(b2) ^ mulb(b3),
              mulb(b0) ^ muld(b1) ^ mul9(b2) ^ mule(b3)};
   endfunction

   // Only COLS_PER_CYCLE column units exist; idx steers them across the work register.
   always_comb begin
      work_nxt = work;
      col      = '0;
      base     = 127;
      for (int g = 0; g < COLS_PER_CYCLE; g++) begin
         col  = idx + 2'(g);
         base = 127 - 32 * int'(col);
         work_nxt[base -: 32] = inv_col(work[base -: 32]);
      end
   end

   assign last = (idx == 2'(4 - COLS_PER_CYCLE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = BUSY;
         end
         BUSY: if (last) state_d = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work      <= '0;
         idx       <= '0;
         state_out <= '0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               work <= state_in;
               idx  <= '0;
            end
            BUSY: begin
               work <= work_nxt;
               idx  <= idx + 2'(COLS_PER_CYCLE);
               if (last) state_out <= work_nxt;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_inv_mix_columns.sv
// Bench for inv_mix_columns at COLS_PER_CYCLE 1, 2 and 4 against a generic GF(2^8) matrix model.
module tb_inv_mix_columns;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid  [3];
   logic         in_ready  [3];
   logic [127:0] state_in  [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic [127:0] state_out [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      inv_mix_columns #(.COLS_PER_CYCLE((g == 0) ? 1 : (g == 1) ? 2 : 4)) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .state_in  (state_in[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .state_out (state_out[g])
      );
   end

   localparam logic [127:0] V1   = 128'h4d7ebdf8_d5d5d7d6_01010101_c6c6c6c6;
   localparam logic [127:0] E1   = 128'h2d26314c_d4d4d4d5_01010101_c6c6c6c6;
   localparam logic [127:0] COLV = 128'h8e4da1bc_9fdc589d_8e4da1bc_9fdc589d;
   localparam logic [127:0] COLE = 128'hdb135345_f20a225c_db135345_f20a225c;

   function automatic int lat(input int k);
      return (k == 0) ? 4 : (k == 1) ? 2 : 1;
   endfunction

   // Shift-and-add GF(2^8) multiply, polynomial 0x11b.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Circulant matrix product per column; inv selects InvMixColumns, else MixColumns.
   function automatic logic [127:0] mixm(input logic [127:0] s, input logic inv);
      logic [7:0]   coef [4];
      logic [7:0]   acc;
      logic [127:0] r = '0;
      if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
      for (int c = 0; c < 4; c++)
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
               acc ^= gmul(coef[(j - row + 4) % 4], s[127 - 32*c - 8*j -: 8]);
            r[127 - 32*c - 8*row -: 8] = acc;
         end
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: one state in flight per instance, checked every cycle at the falling edge.
   int           ncyc = 0;
   logic         pend [3];
   logic         got  [3];
   int           acc_c [3];
   logic [127:0] expv [3];
   logic [127:0] last [3];

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (!rst_n) begin
            pend[k] = 1'b0;
            got[k]  = 1'b0;
            last[k] = '0;
            chk("rst_out_valid", out_valid[k], 0);
            chk("rst_state_out", state_out[k], '0);
         end else begin
            chk("in_ready", in_ready[k], !pend[k]);
            if (pend[k] && !got[k]) begin
               if (ncyc == acc_c[k] + lat(k) + 1) begin
                  chk("latency", out_valid[k], 1);
                  got[k] = out_valid[k];
                  if (!out_valid[k]) pend[k] = 1'b0;
               end else begin
                  chk("early_valid", out_valid[k], 0);
               end
            end else if (!pend[k]) begin
               chk("stray_valid", out_valid[k], 0);
            end
            if (out_valid[k]) chk("state_out", state_out[k], expv[k]);
            else              chk("state_out_held", state_out[k], last[k]);
            if (out_valid[k] && out_ready[k] && got[k]) begin
               pend[k] = 1'b0;
               got[k]  = 1'b0;
               last[k] = expv[k];
            end
            if (in_valid[k] && in_ready[k]) begin
               pend[k]  = 1'b1;
               got[k]   = 1'b0;
               acc_c[k] = ncyc;
               expv[k]  = mixm(state_in[k], 1'b1);
            end
         end
      end
      ncyc++;
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input int k, input logic [127:0] s);
      int t = 0;
      in_valid[k] = 1'b1;
      state_in[k] = s;
      @(negedge clk);
      while (!in_ready[k] && t < 100) begin
         t++;
         @(negedge clk);
      end
      chk("send_accept", in_ready[k], 1);
      @(posedge clk);
      #1;
      in_valid[k] = 1'b0;
   endtask

   task automatic wait_out(input int k, input logic [127:0] exp, input string name);
      int t = 0;
      @(negedge clk);
      while (!out_valid[k] && t < 50) begin
         t++;
         @(negedge clk);
      end
      chk({name, "_valid"}, out_valid[k], 1);
      chk(name, state_out[k], exp);
      @(posedge clk);
      #1;
   endtask

   logic [127:0] orig;
   logic [127:0] seq [3];
   longint       tm  [3];

   initial begin
      for (int k = 0; k < 3; k++) begin
         in_valid[k]  = 1'b0;
         state_in[k]  = '0;
         out_ready[k] = 1'b1;
      end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      chk("model_v1",   mixm(V1, 1'b1), E1);
      chk("model_col",  mixm(COLV, 1'b1), COLE);
      chk("model_fwd",  mixm(E1, 1'b0), V1);
      chk("model_zero", mixm('0, 1'b1), '0);

      for (int k = 0; k < 3; k++) begin
         send(k, V1);
         wait_out(k, E1, "vec_v1");
         send(k, COLV);
         wait_out(k, COLE, "vec_col");
         send(k, '0);
         wait_out(k, '0, "vec_zero");
      end

      for (int i = 0; i < 1000; i++) begin
         orig = {$urandom, $urandom, $urandom, $urandom};
         send(i % 3, mixm(orig, 1'b0));
         wait_out(i % 3, orig, "roundtrip");
      end

      // Backpressure: result must sit unchanged and a waiting state must not get in.
      out_ready[0] = 1'b0;
      send(0, V1);
      wait_out(0, E1, "bp_first");
      in_valid[0] = 1'b1;
      state_in[0] = COLV;
      repeat (10) begin
         @(negedge clk);
         chk("bp_valid_held", out_valid[0], 1);
         chk("bp_out_held", state_out[0], E1);
         chk("bp_not_ready", in_ready[0], 0);
      end
      @(posedge clk);
      #1;
      out_ready[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_ready_return", in_ready[0], 1);
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      wait_out(0, COLE, "bp_next");

      // Back-to-back with in_valid held high.
      seq[0] = V1;
      seq[1] = '0;
      seq[2] = COLV;
      in_valid[0] = 1'b1;
      for (int j = 0; j < 3; j++) begin
         int t = 0;
         state_in[0] = seq[j];
         @(negedge clk);
         while (!in_ready[0] && t < 50) begin
            t++;
            @(negedge clk);
         end
         tm[j] = $time;
         @(posedge clk);
         #1;
      end
      in_valid[0] = 1'b0;
      chk("b2b_interval_1", 128'(tm[1] - tm[0]), 128'd60);
      chk("b2b_interval_2", 128'(tm[2] - tm[1]), 128'd60);
      wait_out(0, COLE, "b2b_last");

      // Reset in the second BUSY cycle.
      send(0, V1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", out_valid[0], 0);
      chk("rst_mid_out", state_out[0], '0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("rst_no_stale", out_valid[0], 0);
      @(posedge clk);
      #1;
      send(0, V1);
      wait_out(0, E1, "rst_recover");

      repeat (4) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
